// File: rtl/display_pkg.sv
// Shared display definitions: default VGA timing, RGB565 pixel format and the
// scan-out frame-handshake state encoding.
package display_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef enum logic [1:0] {
        IDLE,
        RENDER,
        READY
    } scanout_state_t;

endpackage

// File: rtl/framebuffer_scanout_if.sv
// Scan-out bus: framebuffer read port, frame handshake with the generator and
// the raster video outputs. master = scan-out side.
interface framebuffer_scanout_if #(
    parameter int ADDR_BITS = 14,
    parameter int DATA_BITS = 16
);

    logic [ADDR_BITS-1:0]  fb_rd_addr;
    logic [DATA_BITS-1:0]  fb_rd_data;
    logic                  fb_disp_sel;
    logic                  frame_start;
    logic                  frame_done;
    logic                  hsync;
    logic                  vsync;
    logic                  de;
    display_pkg::rgb565_t  rgb;
    logic [7:0]            dropped_frames;

    modport master (
        output fb_rd_addr, fb_disp_sel, frame_start, hsync, vsync, de, rgb, dropped_frames,
        input  fb_rd_data, frame_done
    );

    modport slave (
        input  fb_rd_addr, fb_disp_sel, frame_start, hsync, vsync, de, rgb, dropped_frames,
        output fb_rd_data, frame_done
    );

endinterface

// File: rtl/raster_timing.sv
// Free-running h/v raster counters advancing on pix_en, with undelayed sync and
// active-video flags and the one-clk vblank-start strobe.
module raster_timing import display_pkg::*; #(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    localparam int H_TOT   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOT   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW      = $clog2(H_TOT),
    localparam int VW      = $clog2(V_TOT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_en,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          hsync_act,
    output logic          vsync_act,
    output logic          de_act,
    output logic          vb_start
);

    always_ff @(posedge clk) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (pix_en) begin
            if (h == HW'(H_TOT - 1)) begin
                h <= '0;
                if (v == VW'(V_TOT - 1)) begin
                    v <= '0;
                end else begin
                    v <= v + 1'b1;
                end
            end else begin
                h <= h + 1'b1;
            end
        end
    end

    assign hsync_act = (h >= HW'(H_ACTIVE + H_FP)) && (h < HW'(H_ACTIVE + H_FP + H_SYNC));
    assign vsync_act = (v >= VW'(V_ACTIVE + V_FP)) && (v < VW'(V_ACTIVE + V_FP + V_SYNC));
    assign de_act    = (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
    assign vb_start  = pix_en && (h == '0) && (v == VW'(V_ACTIVE));

endmodule

// File: rtl/framebuffer_scanout.sv
// Framebuffer scan-out: replicated-pixel address generation, two-stage video
// pipeline and the double-buffer frame handshake with the video generator.
module framebuffer_scanout import display_pkg::*; #(
    parameter int H_ACTIVE              = DEF_H_ACTIVE,
    parameter int H_FP                  = DEF_H_FP,
    parameter int H_SYNC                = DEF_H_SYNC,
    parameter int H_BP                  = DEF_H_BP,
    parameter int V_ACTIVE              = DEF_V_ACTIVE,
    parameter int V_FP                  = DEF_V_FP,
    parameter int V_SYNC                = DEF_V_SYNC,
    parameter int V_BP                  = DEF_V_BP,
    parameter int DISPLAY_WIDTH         = 100,
    parameter int DISPLAY_HEIGHT        = 100,
    parameter int SCALE                 = 4,
    parameter int FRAMEBUFFER_DATA_BITS = 16,
    parameter int FRAMEBUFFER_ADDR_BITS = $clog2(DISPLAY_WIDTH * DISPLAY_HEIGHT),
    parameter bit SYNC_ACTIVE_LOW       = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  pix_en,
    framebuffer_scanout_if.master bus
);

    localparam int HW    = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VW    = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int WIN_W = DISPLAY_WIDTH * SCALE;
    localparam int WIN_H = DISPLAY_HEIGHT * SCALE;
    localparam int SW    = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int PXW   = $clog2(DISPLAY_WIDTH + 1);
    localparam int AW    = FRAMEBUFFER_ADDR_BITS;

    logic [HW-1:0]  h;
    logic [VW-1:0]  v;
    logic           hs_act, vs_act, de_act, vb_start, in_win;
    logic [SW-1:0]  sx, sy;
    logic [PXW-1:0] px;
    logic [AW-1:0]  line_base;

    raster_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk(clk), .rst(rst), .pix_en(pix_en), .h(h), .v(v),
        .hsync_act(hs_act), .vsync_act(vs_act), .de_act(de_act), .vb_start(vb_start)
    );

    assign in_win = (h < HW'(WIN_W)) && (v < VW'(WIN_H));

    // Replication sub-counters track h/v; px and line_base stop stepping at the
    // window edge so they never exceed the image.
    always_ff @(posedge clk) begin
        if (rst) begin
            sx        <= '0;
            sy        <= '0;
            px        <= '0;
            line_base <= '0;
        end else if (pix_en) begin
            if (h == HW'(H_TOT - 1)) begin
                sx <= '0;
                px <= '0;
                if (v == VW'(V_TOT - 1)) begin
                    sy        <= '0;
                    line_base <= '0;
                end else if (v < VW'(WIN_H)) begin
                    if (sy == SW'(SCALE - 1)) begin
                        sy        <= '0;
                        line_base <= line_base + AW'(DISPLAY_WIDTH);
                    end else begin
                        sy <= sy + 1'b1;
                    end
                end
            end else if (h < HW'(WIN_W)) begin
                if (sx == SW'(SCALE - 1)) begin
                    sx <= '0;
                    px <= px + 1'b1;
                end else begin
                    sx <= sx + 1'b1;
                end
            end
        end
    end

    // p0: read address registered; raster flags follow
    logic [AW-1:0] addr_p0;
    logic          de_p0, hs_p0, vs_p0, win_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_p0 <= '0;
            de_p0   <= 1'b0;
            hs_p0   <= 1'b0;
            vs_p0   <= 1'b0;
            win_p0  <= 1'b0;
        end else if (pix_en) begin
            if (in_win) begin
                addr_p0 <= line_base + AW'(px);
            end
            de_p0  <= de_act;
            hs_p0  <= hs_act;
            vs_p0  <= vs_act;
            win_p0 <= in_win;
        end
    end

    // p1: read data captured, blanked outside the image
    rgb565_t rgb_p1;
    logic    de_p1, hs_p1, vs_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_p1 <= '0;
            de_p1  <= 1'b0;
            hs_p1  <= 1'b0;
            vs_p1  <= 1'b0;
        end else if (pix_en) begin
            if (de_p0 && win_p0) begin
                rgb_p1 <= rgb565_t'(bus.fb_rd_data[FRAMEBUFFER_DATA_BITS-1 -: 16]);
            end else begin
                rgb_p1 <= '0;
            end
            de_p1 <= de_p0;
            hs_p1 <= hs_p0;
            vs_p1 <= vs_p0;
        end
    end

    assign bus.fb_rd_addr = addr_p0;
    assign bus.de         = de_p1;
    assign bus.rgb        = rgb_p1;
    assign bus.hsync      = hs_p1 ^ SYNC_ACTIVE_LOW;
    assign bus.vsync      = vs_p1 ^ SYNC_ACTIVE_LOW;

    scanout_state_t state, state_nxt;
    logic           start_nxt, swap, drop;
    logic           frame_start_q, disp_sel_q;
    logic [7:0]     dropped_q;

    // A frame_done arriving in the vblank-start clk counts as on time.
    always_comb begin
        state_nxt = state;
        start_nxt = 1'b0;
        swap      = 1'b0;
        drop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (vb_start) begin
                    start_nxt = 1'b1;
                    state_nxt = RENDER;
                end
            end
            RENDER: begin
                if (bus.frame_done && vb_start) begin
                    swap      = 1'b1;
                    start_nxt = 1'b1;
                end else if (bus.frame_done) begin
                    state_nxt = READY;
                end else if (vb_start) begin
                    drop = 1'b1;
                end
            end
            READY: begin
                if (vb_start) begin
                    swap      = 1'b1;
                    start_nxt = 1'b1;
                    state_nxt = RENDER;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            frame_start_q <= 1'b0;
            disp_sel_q    <= 1'b0;
            dropped_q     <= '0;
        end else begin
            state         <= state_nxt;
            frame_start_q <= start_nxt;
            if (swap) begin
                disp_sel_q <= ~disp_sel_q;
            end
            if (drop && (dropped_q != 8'hFF)) begin
                dropped_q <= dropped_q + 1'b1;
            end
        end
    end

    assign bus.frame_start    = frame_start_q;
    assign bus.fb_disp_sel    = disp_sel_q;
    assign bus.dropped_frames = dropped_q;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Directed bench for framebuffer_scanout on a shrunken raster (24x17 clks per
// frame, 3x2 image replicated 4x) so several frames fit in a short run.
module tb_framebuffer_scanout;

    localparam int HA = 16, HFP = 2, HS = 4, HB = 2;
    localparam int VA = 12, VFP = 1, VS = 2, VB = 2;
    localparam int DW = 3, DH = 2, SC = 4;
    localparam int HT = HA + HFP + HS + HB;
    localparam int VT = VA + VFP + VS + VB;
    localparam int AB = $clog2(DW * DH);

    logic clk = 1'b0;
    logic rst;
    logic pix_en;

    int n_tests = 0;
    int n_fail  = 0;
    int pos     = 0;
    int hs_low, vs_low, fs_cnt, fs_pos;

    framebuffer_scanout_if #(.ADDR_BITS(AB), .DATA_BITS(16)) bus ();

    framebuffer_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
        .DISPLAY_WIDTH(DW), .DISPLAY_HEIGHT(DH), .SCALE(SC),
        .FRAMEBUFFER_DATA_BITS(16), .FRAMEBUFFER_ADDR_BITS(AB),
        .SYNC_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .pix_en(pix_en), .bus(bus)
    );

    always #5 clk = ~clk;

    // Framebuffer contents: a recognisable tag plus the address.
    function automatic logic [15:0] fb_word(input int k);
        return 16'hA500 + 16'(k);
    endfunction

    assign bus.fb_rd_data = fb_word(int'(bus.fb_rd_addr));

    logic [15:0] rgb_w;
    assign rgb_w = bus.rgb;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string pre);
        check({pre, "_hsync"}, 32'(bus.hsync), 32'd1);
        check({pre, "_vsync"}, 32'(bus.vsync), 32'd1);
        check({pre, "_de"}, 32'(bus.de), 32'd0);
        check({pre, "_rgb"}, 32'(rgb_w), 32'd0);
        check({pre, "_addr"}, 32'(bus.fb_rd_addr), 32'd0);
        check({pre, "_sel"}, 32'(bus.fb_disp_sel), 32'd0);
        check({pre, "_fstart"}, 32'(bus.frame_start), 32'd0);
        check({pre, "_dropped"}, 32'(bus.dropped_frames), 32'd0);
    endtask

    // Outputs lag the raster position by two enabled pixel clocks.
    task automatic check_video();
        int p, h, v;
        logic ehs, evs, ede;
        logic [15:0] ergb;
        p = pos - 2;
        if (p < 0) begin
            ehs = 1'b1; evs = 1'b1; ede = 1'b0; ergb = 16'h0;
        end else begin
            h = p % HT;
            v = (p / HT) % VT;
            ehs = !((h >= HA + HFP) && (h < HA + HFP + HS));
            evs = !((v >= VA + VFP) && (v < VA + VFP + VS));
            ede = (h < HA) && (v < VA);
            ergb = ((h < DW * SC) && (v < DH * SC)) ? fb_word((v / SC) * DW + h / SC) : 16'h0;
        end
        check("hsync", 32'(bus.hsync), 32'(ehs));
        check("vsync", 32'(bus.vsync), 32'(evs));
        check("de", 32'(bus.de), 32'(ede));
        check("rgb", 32'(rgb_w), 32'(ergb));
    endtask

    task automatic step(input logic en);
        pix_en = en;
        @(negedge clk);
        if (en) pos++;
    endtask

    task automatic run(input int n, input bit half);
        for (int i = 0; i < n; i++) begin
            step(half ? logic'(i % 2 == 0) : 1'b1);
            check_video();
            if (bus.hsync === 1'b0) hs_low++;
            if (bus.vsync === 1'b0) vs_low++;
            if (bus.frame_start === 1'b1) begin
                fs_cnt++;
                fs_pos = pos;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        pix_en = 1'b0;
        bus.frame_done = 1'b0;
        hs_low = 0; vs_low = 0; fs_cnt = 0; fs_pos = -1;
        repeat (3) @(negedge clk);
        check_reset("rst");

        rst = 1'b0;
        pos = 0;
        run(1, 1'b0);
        check("de_before_latency", 32'(bus.de), 32'd0);
        run(1, 1'b0);
        check("de_first_rise", 32'(bus.de), 32'd1);
        check("rgb_first_pixel", 32'(rgb_w), 32'hA500);

        // Frame 0: addressing inside and just past the image window on line 5.
        hs_low = 0; vs_low = 0;
        run(129, 1'b0);
        check("addr_v5_h10", 32'(bus.fb_rd_addr), 32'd5);
        check("rgb_v5_h9", 32'(rgb_w), 32'hA505);
        run(4, 1'b0);
        check("addr_hold_outside", 32'(bus.fb_rd_addr), 32'd5);
        check("rgb_blank_h13", 32'(rgb_w), 32'd0);
        check("de_h13", 32'(bus.de), 32'd1);
        run(275, 1'b0);
        check("hsync_low_clks", 32'(hs_low), 32'd68);
        check("vsync_low_clks", 32'(vs_low), 32'd48);
        check("first_fstart_cnt", 32'(fs_cnt), 32'd1);
        check("first_fstart_pos", 32'(fs_pos), 32'd289);
        check("sel_frame0", 32'(bus.fb_disp_sel), 32'd0);

        // Generator finishes in time: swap at the next vblank.
        bus.frame_done = 1'b1;
        run(1, 1'b0);
        bus.frame_done = 1'b0;
        fs_cnt = 0;
        run(300, 1'b0);
        check("ontime_fstart_cnt", 32'(fs_cnt), 32'd1);
        check("ontime_fstart_pos", 32'(fs_pos), 32'd697);
        check("ontime_sel", 32'(bus.fb_disp_sel), 32'd1);
        check("ontime_dropped", 32'(bus.dropped_frames), 32'd0);

        // Generator late for three vblanks.
        fs_cnt = 0;
        run(1219, 1'b0);
        check("late_fstart_cnt", 32'(fs_cnt), 32'd0);
        check("late_sel", 32'(bus.fb_disp_sel), 32'd1);
        check("late_dropped", 32'(bus.dropped_frames), 32'd3);
        bus.frame_done = 1'b1;
        run(3, 1'b0);
        bus.frame_done = 1'b0;
        run(400, 1'b0);
        check("recover_fstart_cnt", 32'(fs_cnt), 32'd1);
        check("recover_fstart_pos", 32'(fs_pos), 32'd2329);
        check("recover_sel", 32'(bus.fb_disp_sel), 32'd0);
        check("recover_dropped", 32'(bus.dropped_frames), 32'd3);

        // frame_done in the very clk of vblank start.
        run(403, 1'b0);
        bus.frame_done = 1'b1;
        fs_cnt = 0;
        run(1, 1'b0);
        bus.frame_done = 1'b0;
        check("same_clk_fstart", 32'(bus.frame_start), 32'd1);
        check("same_clk_sel", 32'(bus.fb_disp_sel), 32'd1);
        check("same_clk_dropped", 32'(bus.dropped_frames), 32'd3);
        run(10, 1'b0);
        check("same_clk_single_pulse", 32'(fs_cnt), 32'd1);

        // pix_en on every other clk: timing stretches 2x, one more drop.
        hs_low = 0; vs_low = 0; fs_cnt = 0;
        run(816, 1'b1);
        check("half_hsync_low_clks", 32'(hs_low), 32'd136);
        check("half_vsync_low_clks", 32'(vs_low), 32'd96);
        check("half_fstart_cnt", 32'(fs_cnt), 32'd0);
        check("half_dropped", 32'(bus.dropped_frames), 32'd4);
        run(372, 1'b1);
        check("pre_rst_rgb", 32'(rgb_w), 32'hA500);
        check("pre_rst_sel", 32'(bus.fb_disp_sel), 32'd1);

        // Reset mid-line with frame_done asserted during reset.
        rst = 1'b1;
        bus.frame_done = 1'b1;
        pix_en = 1'b0;
        @(negedge clk);
        check_reset("midrst");
        @(negedge clk);
        rst = 1'b0;
        bus.frame_done = 1'b0;
        pos = 0;
        fs_cnt = 0;
        run(300, 1'b0);
        check("post_rst_fstart_cnt", 32'(fs_cnt), 32'd1);
        check("post_rst_fstart_pos", 32'(fs_pos), 32'd289);
        run(400, 1'b0);
        check("post_rst_sel", 32'(bus.fb_disp_sel), 32'd0);
        check("post_rst_dropped", 32'(bus.dropped_frames), 32'd1);
        check("post_rst_fstart_total", 32'(fs_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
